// File: rtl/packed_lane_fifo_if.sv
// Handshake bundle for packed_lane_fifo: producer push side, consumer pop side and status.
// "slave" is the FIFO's view of the bundle; "master" is the view of the block driving it.
interface packed_lane_fifo_if #(
   parameter int LANES  = 2,
   parameter int DATA_W = 1,
   parameter int DEPTH  = 4
);
   localparam int EW = LANES * (DATA_W + 1);

   logic                         in_valid;
   logic                         in_ready;
   logic [EW-1:0]                in_data;
   logic                         out_valid;
   logic                         out_ready;
   logic [EW-1:0]                out_data;
   logic [$clog2(LANES+1)-1:0]   out_lane_cnt;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_lane_cnt, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_lane_cnt, count
   );
endinterface

// File: rtl/packed_lane_fifo.sv
// First-word-fall-through FIFO of packed lane-struct entries {vld, data}, with data masking
// on invalid lanes, optional dropping of all-invalid entries and a head active-lane count.
module packed_lane_fifo #(
   parameter int LANES      = 2,
   parameter int DATA_W     = 1,
   parameter int DEPTH      = 4,
   parameter int DROP_EMPTY = 0
) (
   input  logic                clk,
   input  logic                rst,
   packed_lane_fifo_if.slave   bus
);
   localparam int LW = DATA_W + 1;
   localparam int EW = LANES * LW;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int NW = $clog2(LANES + 1);

   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [EW-1:0]    wr_entry;
   logic [EW-1:0]    head;
   logic [LANES-1:0] in_vld;
   logic [LANES-1:0] out_vld;
   logic [NW-1:0]    lane_cnt;
   logic             in_ready;
   logic             out_valid;
   logic             push;
   logic             pop;
   logic             store;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign in_vld[gi]              = bus.in_data[gi*LW + DATA_W];
         // Invalid lanes are stored with a zero data field so stale bits never reach the consumer.
         assign wr_entry[gi*LW +: LW]   = in_vld[gi] ? bus.in_data[gi*LW +: LW] : '0;
         assign out_vld[gi]             = head[gi*LW + DATA_W];
      end
   endgenerate

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

   assign push  = bus.in_valid && in_ready;
   assign pop   = out_valid && bus.out_ready;
   // A dropped entry completes its handshake but behaves as no push for pointers and count.
   assign store = push && ((DROP_EMPTY == 0) || (|in_vld));

   always_comb begin
      lane_cnt = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_cnt = lane_cnt + NW'(out_vld[k]);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (store) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({store, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store && !rst) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid;
   assign bus.out_data     = head;
   assign bus.out_lane_cnt = lane_cnt;
   assign bus.count        = count_q;
endmodule

// File: tb/tb_packed_lane_fifo.sv
// Bench for packed_lane_fifo: a table of hand-derived vectors, directed corner sequences and
// random traffic checked against a queue model, on a keep-empty and a drop-empty instance.
module tb_packed_lane_fifo;
   localparam int LANES  = 2;
   localparam int DATA_W = 1;
   localparam int DEPTH  = 4;
   localparam int LW     = DATA_W + 1;
   localparam int EW     = LANES * LW;

   typedef logic [EW-1:0] entry_t;

   typedef struct {
      logic   in_valid;
      entry_t in_data;
      logic   out_ready;
      logic   exp_out_valid;
      entry_t exp_out_data;
      int     exp_lane_cnt;
      int     exp_count;
      logic   exp_in_ready;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   iv;
   logic   ordy;
   entry_t idata;

   int n_checks = 0;
   int n_fail   = 0;

   entry_t q0[$];
   entry_t q1[$];

   always #5 clk = ~clk;

   packed_lane_fifo_if #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
   packed_lane_fifo_if #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

   assign bus0.in_valid  = iv;
   assign bus0.in_data   = idata;
   assign bus0.out_ready = ordy;
   assign bus1.in_valid  = iv;
   assign bus1.in_data   = idata;
   assign bus1.out_ready = ordy;

   packed_lane_fifo #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_EMPTY(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   packed_lane_fifo #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_EMPTY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   function automatic logic lane_vld(entry_t e, int k);
      return e[k*LW + DATA_W];
   endfunction

   function automatic entry_t norm(entry_t e);
      entry_t r = e;
      for (int k = 0; k < LANES; k++) begin
         if (!lane_vld(e, k)) r[k*LW +: DATA_W] = '0;
      end
      return r;
   endfunction

   function automatic int vld_cnt(entry_t e);
      int c = 0;
      for (int k = 0; k < LANES; k++) c += int'(lane_vld(e, k));
      return c;
   endfunction

   function automatic logic has_dirty_lane(entry_t e);
      logic bad = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if (!lane_vld(e, k) && (e[k*LW +: DATA_W] != '0)) bad = 1'b1;
      end
      return bad;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check(string tag, int qsize, entry_t qhead, logic ir, logic ov,
                              entry_t od, logic [63:0] lc, logic [63:0] cnt);
      entry_t exp_od;
      exp_od = (qsize != 0) ? qhead : entry_t'(0);
      chk({tag, ".in_ready"},     64'(ir),  64'(qsize != DEPTH));
      chk({tag, ".out_valid"},    64'(ov),  64'(qsize != 0));
      chk({tag, ".out_data"},     64'(od),  64'(exp_od));
      chk({tag, ".out_lane_cnt"}, lc,       64'(vld_cnt(exp_od)));
      chk({tag, ".count"},        cnt,      64'(qsize));
      chk({tag, ".dirty_lane"},   64'(has_dirty_lane(od)), 64'(0));
   endtask

   task automatic drive(logic v, entry_t d, logic r);
      iv    = v;
      idata = d;
      ordy  = r;
      #1;
   endtask

   // Compare both instances against their queues, clock once, then advance the queues.
   task automatic cycle();
      bit push0, pop0, push1, pop1;
      model_check("d0", q0.size(), (q0.size() != 0) ? q0[0] : entry_t'(0), bus0.in_ready,
                  bus0.out_valid, bus0.out_data, 64'(bus0.out_lane_cnt), 64'(bus0.count));
      model_check("d1", q1.size(), (q1.size() != 0) ? q1[0] : entry_t'(0), bus1.in_ready,
                  bus1.out_valid, bus1.out_data, 64'(bus1.out_lane_cnt), 64'(bus1.count));
      push0 = iv && (q0.size() != DEPTH);
      pop0  = ordy && (q0.size() != 0);
      push1 = iv && (q1.size() != DEPTH);
      pop1  = ordy && (q1.size() != 0);
      @(posedge clk);
      #1;
      if (rst) begin
         q0.delete();
         q1.delete();
      end else begin
         if (pop0) void'(q0.pop_front());
         if (push0) q0.push_back(norm(idata));
         if (pop1) void'(q1.pop_front());
         if (push1 && vld_cnt(idata) != 0) q1.push_back(norm(idata));
      end
   endtask

   task automatic drain();
      drive(1'b0, '0, 1'b1);
      repeat (DEPTH + 1) cycle();
      drive(1'b0, '0, 1'b0);
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b1, 4'b1101, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b1};
      vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b1100, 1, 1, 1'b1};
      vecs[2]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b1};
      vecs[3]  = '{1'b1, 4'b0011, 1'b0, 1'b1, 4'b1010, 2, 1, 1'b1};
      vecs[4]  = '{1'b1, 4'b1111, 1'b0, 1'b1, 4'b1010, 2, 2, 1'b1};
      vecs[5]  = '{1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 2, 3, 1'b1};
      vecs[6]  = '{1'b1, 4'b1000, 1'b0, 1'b1, 4'b1010, 2, 4, 1'b0};
      vecs[7]  = '{1'b1, 4'b1000, 1'b1, 1'b1, 4'b1010, 2, 4, 1'b0};
      vecs[8]  = '{1'b1, 4'b1000, 1'b1, 1'b1, 4'b0011, 1, 3, 1'b1};
      vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2, 3, 1'b1};
      vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0010, 1, 2, 1'b1};
      vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b1000, 1, 1, 1'b1};
      vecs[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 0, 1'b1};

      rst = 1'b1;
      drive(1'b0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q0.delete();
      q1.delete();

      for (int i = 0; i < 10; i++) begin
         chk("idle.out_valid", 64'(bus0.out_valid), 64'(0));
         chk("idle.out_data",  64'(bus0.out_data),  64'(0));
         chk("idle.count",     64'(bus0.count),     64'(0));
         chk("idle.in_ready",  64'(bus0.in_ready),  64'(1));
         cycle();
      end

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
         chk($sformatf("vec%0d.out_valid", i), 64'(bus0.out_valid), 64'(vecs[i].exp_out_valid));
         chk($sformatf("vec%0d.out_data", i), 64'(bus0.out_data), 64'(vecs[i].exp_out_data));
         chk($sformatf("vec%0d.lane_cnt", i), 64'(bus0.out_lane_cnt), 64'(vecs[i].exp_lane_cnt));
         chk($sformatf("vec%0d.count", i), 64'(bus0.count), 64'(vecs[i].exp_count));
         chk($sformatf("vec%0d.in_ready", i), 64'(bus0.in_ready), 64'(vecs[i].exp_in_ready));
         cycle();
      end

      // All-invalid middle entry is swallowed by the drop-empty instance.
      drive(1'b1, 4'b1011, 1'b0);
      chk("drop.ready0", 64'(bus1.in_ready), 64'(1));
      chk("drop.count0", 64'(bus1.count), 64'(0));
      cycle();
      drive(1'b1, 4'b0100, 1'b0);
      chk("drop.ready1", 64'(bus1.in_ready), 64'(1));
      chk("drop.count1", 64'(bus1.count), 64'(1));
      cycle();
      drive(1'b1, 4'b1110, 1'b0);
      chk("drop.ready2", 64'(bus1.in_ready), 64'(1));
      chk("drop.count2", 64'(bus1.count), 64'(1));
      cycle();
      drive(1'b0, '0, 1'b1);
      chk("drop.peak", 64'(bus1.count), 64'(2));
      chk("drop.first", 64'(bus1.out_data), 64'(4'b1011));
      cycle();
      chk("drop.second", 64'(bus1.out_data), 64'(4'b1110));
      cycle();
      chk("drop.empty", 64'(bus1.count), 64'(0));
      drain();

      drive(1'b1, EW'($urandom), 1'b0);
      cycle();
      drive(1'b1, EW'($urandom), 1'b0);
      cycle();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, EW'($urandom), 1'b1);
         chk($sformatf("stream%0d.count", i), 64'(bus0.count), 64'(2));
         cycle();
      end
      drain();

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, EW'($urandom), 1'b0);
         cycle();
      end
      chk("rst.filled", 64'(bus0.count), 64'(3));
      rst = 1'b1;
      drive(1'b1, EW'($urandom), 1'b0);
      cycle();
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      chk("rst.count", 64'(bus0.count), 64'(0));
      chk("rst.out_valid", 64'(bus0.out_valid), 64'(0));
      drive(1'b1, 4'b1001, 1'b0);
      cycle();
      drive(1'b0, '0, 1'b1);
      chk("rst.after_data", 64'(bus0.out_data), 64'(4'b1000));
      chk("rst.after_cnt", 64'(bus0.out_lane_cnt), 64'(1));
      cycle();

      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         drive(($urandom_range(0, 9) < 7), EW'($urandom), $urandom_range(0, 1) == 1);
         cycle();
      end
      rst = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
